// File: rtl/modbus_rtu_tx_framer.sv
// Modbus RTU transmit framer: enforces the inter-frame silent gap, then streams frame_len payload bytes to a UART byte TX.
// Optional CRC16 trailer (low byte first) is built in when MODBUS_TX_CRC_EN is defined.
module modbus_rtu_tx_framer #(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 115200
) (
    input  logic       sys_clk,
    input  logic       reset_n,
    input  logic       frame_start,
    input  logic [7:0] frame_len,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx_start,
    output logic [7:0] tx_data,
    input  logic       tx_done,
    output logic       busy,
    output logic       frame_done
);

    // Above 19200 baud the silent interval is fixed at 1.75 ms, otherwise 3.5 character times.
    localparam logic [63:0] GAP_L = (BAUD_RATE > 19200)
                                  ? (64'(CLK_FREQ) * 64'd7) / 64'd4000
                                  : (64'(CLK_FREQ) * 64'd385) / (64'(BAUD_RATE) * 64'd10);
    localparam logic [31:0] GAP_CYCLES = GAP_L[31:0];

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        GAP_WAIT  = 3'd1,
        FETCH     = 3'd2,
        SEND      = 3'd3,
        WAIT_DONE = 3'd4,
        CRC_LO    = 3'd5,
        CRC_HI    = 3'd6,
        DONE      = 3'd7
    } state_t;

    state_t      state_q;
    logic [7:0]  remain_q;
    logic        in_ready_q;
    logic        tx_start_q;
    logic [7:0]  tx_data_q;
    logic        busy_q;
    logic        frame_done_q;

    logic [31:0] gap_q;
    logic [31:0] gap_d;
    logic        gap_ok;
    logic        start_ok;
    logic        accept;

    assign start_ok = (state_q == IDLE) && frame_start && (frame_len != 8'd0);
    assign accept   = (state_q == FETCH) && in_valid && in_ready_q;
    assign gap_ok   = (gap_q == GAP_CYCLES);

    // Line-idle timer: restarts when a frame finishes, saturates once the gap has elapsed.
    always_comb begin
        gap_d = gap_q;
        if (frame_done_q) begin
            gap_d = '0;
        end else if (!gap_ok) begin
            gap_d = gap_q + 32'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            gap_q <= '0;
        end else begin
            gap_q <= gap_d;
        end
    end

`ifdef MODBUS_TX_CRC_EN
    logic [15:0] crc_q;
    logic [15:0] crc_d;
    logic [3:0]  crc_cnt_q;
    logic [3:0]  crc_cnt_d;
    logic [1:0]  crc_phase_q;

    // Bit-serial CRC16: the byte is folded in on accept, then shifted out over 8 cycles.
    always_comb begin
        crc_d     = crc_q;
        crc_cnt_d = crc_cnt_q;
        if (start_ok) begin
            crc_d     = 16'hFFFF;
            crc_cnt_d = 4'd0;
        end else if (accept) begin
            crc_d     = crc_q ^ {8'h00, in_data};
            crc_cnt_d = 4'd8;
        end else if (crc_cnt_q != 4'd0) begin
            crc_d     = crc_q[0] ? ((crc_q >> 1) ^ 16'hA001) : (crc_q >> 1);
            crc_cnt_d = crc_cnt_q - 4'd1;
        end
    end

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q     <= 16'hFFFF;
            crc_cnt_q <= 4'd0;
        end else begin
            crc_q     <= crc_d;
            crc_cnt_q <= crc_cnt_d;
        end
    end
`endif

    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            remain_q     <= 8'd0;
            in_ready_q   <= 1'b0;
            tx_start_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
`ifdef MODBUS_TX_CRC_EN
            crc_phase_q  <= 2'd0;
`endif
        end else begin
            tx_start_q   <= 1'b0;
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_ok) begin
                        remain_q <= frame_len;
                        busy_q   <= 1'b1;
`ifdef MODBUS_TX_CRC_EN
                        crc_phase_q <= 2'd0;
`endif
                        if (gap_ok) begin
                            state_q    <= FETCH;
                            in_ready_q <= 1'b1;
                        end else begin
                            state_q <= GAP_WAIT;
                        end
                    end
                end
                GAP_WAIT: begin
                    if (gap_ok) begin
                        state_q    <= FETCH;
                        in_ready_q <= 1'b1;
                    end
                end
                FETCH: begin
                    if (accept) begin
                        tx_data_q  <= in_data;
                        remain_q   <= remain_q - 8'd1;
                        in_ready_q <= 1'b0;
                        tx_start_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    state_q <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (tx_done) begin
                        if (remain_q != 8'd0) begin
                            state_q    <= FETCH;
                            in_ready_q <= 1'b1;
                        end else begin
`ifdef MODBUS_TX_CRC_EN
                            case (crc_phase_q)
                                2'd0:    state_q <= CRC_LO;
                                2'd1:    state_q <= CRC_HI;
                                default: begin
                                    state_q      <= DONE;
                                    frame_done_q <= 1'b1;
                                    busy_q       <= 1'b0;
                                end
                            endcase
`else
                            state_q      <= DONE;
                            frame_done_q <= 1'b1;
                            busy_q       <= 1'b0;
`endif
                        end
                    end
                end
                CRC_LO: begin
`ifdef MODBUS_TX_CRC_EN
                    tx_data_q   <= crc_q[7:0];
                    tx_start_q  <= 1'b1;
                    crc_phase_q <= 2'd1;
                    state_q     <= SEND;
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                CRC_HI: begin
`ifdef MODBUS_TX_CRC_EN
                    tx_data_q   <= crc_q[15:8];
                    tx_start_q  <= 1'b1;
                    crc_phase_q <= 2'd2;
                    state_q     <= SEND;
`else
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_q;
    assign tx_start   = tx_start_q;
    assign tx_data    = tx_data_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;

endmodule
